// File: rtl/gpio_pkg.sv
// Purpose: shared constants for the GPIO bank (register offsets, edge-sense modes).
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_pkg;

   // Register offsets within one port's 8-address window
   localparam logic [2:0] GPIO_DIR      = 3'd0;
   localparam logic [2:0] GPIO_OUT      = 3'd1;
   localparam logic [2:0] GPIO_OUTSET   = 3'd2;
   localparam logic [2:0] GPIO_OUTCLR   = 3'd3;
   localparam logic [2:0] GPIO_OUTTGL   = 3'd4;
   localparam logic [2:0] GPIO_IN       = 3'd5;
   localparam logic [2:0] GPIO_INTMASK  = 3'd6;
   localparam logic [2:0] GPIO_INTFLAGS = 3'd7;

   // Pin-change sense selection
   localparam int EDGE_BOTH = 0;
   localparam int EDGE_RISE = 1;
   localparam int EDGE_FALL = 2;

endpackage

// File: rtl/gpio_port.sv
// Purpose: one GPIO port - DIR/OUT/INTMASK/INTFLAGS registers, input synchroniser, pin-change detect.
// Latency: register writes commit at the strobe edge; reads combinational; pad->IN SYNC_STAGES edges, pad->flag SYNC_STAGES+1.
// Backpressure: none; every access completes in the cycle it is presented.
// Ports: clk/rst (sync, active high); arm enables flag setting; sel/we/offset/wr_dat form the
//        local register access; rd_dat is 0 unless sel; pin_in pads; pin_out/pin_oe drive; irq = |(flags & mask).
module gpio_port
   import gpio_pkg::*;
#(
   parameter int PORT_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = EDGE_BOTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  sel,
   input  logic                  we,
   input  logic [2:0]            offset,
   input  logic [PORT_WIDTH-1:0] wr_dat,
   output logic [7:0]            rd_dat,
   input  logic [PORT_WIDTH-1:0] pin_in,
   output logic [PORT_WIDTH-1:0] pin_out,
   output logic [PORT_WIDTH-1:0] pin_oe,
   output logic                  irq
);

   logic [PORT_WIDTH-1:0] dir_q;
   logic [PORT_WIDTH-1:0] out_q;
   logic [PORT_WIDTH-1:0] mask_q;
   logic [PORT_WIDTH-1:0] flags_q;
   logic [PORT_WIDTH-1:0] prev_q;
   logic [PORT_WIDTH-1:0] sync_q [SYNC_STAGES];

   logic [PORT_WIDTH-1:0] in_val;
   logic [PORT_WIDTH-1:0] det;
   logic [PORT_WIDTH-1:0] w1c;
   logic [PORT_WIDTH-1:0] rd_val;
   logic                  wr_en;

   assign in_val = sync_q[SYNC_STAGES-1];
   assign wr_en  = sel & we;

   always_comb begin
      if (EDGE_MODE == EDGE_RISE)
         det = in_val & ~prev_q;
      else if (EDGE_MODE == EDGE_FALL)
         det = ~in_val & prev_q;
      else
         det = in_val ^ prev_q;
   end

   assign w1c = (wr_en && offset == GPIO_INTFLAGS) ? wr_dat : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q   <= '0;
         out_q   <= '0;
         mask_q  <= '0;
         flags_q <= '0;
         prev_q  <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= pin_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= in_val;
         // Clear first, then OR in new events so a coincident edge survives the clear
         flags_q <= (flags_q & ~w1c) | (arm ? det : '0);
         if (wr_en) begin
            case (offset)
               GPIO_DIR:     dir_q  <= wr_dat;
               GPIO_OUT:     out_q  <= wr_dat;
               GPIO_OUTSET:  out_q  <= out_q | wr_dat;
               GPIO_OUTCLR:  out_q  <= out_q & ~wr_dat;
               GPIO_OUTTGL:  out_q  <= out_q ^ wr_dat;
               GPIO_INTMASK: mask_q <= wr_dat;
               default:      ;
            endcase
         end
      end
   end

   always_comb begin
      case (offset)
         GPIO_DIR:      rd_val = dir_q;
         GPIO_IN:       rd_val = in_val;
         GPIO_INTMASK:  rd_val = mask_q;
         GPIO_INTFLAGS: rd_val = flags_q;
         default:       rd_val = out_q;   // OUT and the three strobe offsets
      endcase
   end

   always_comb begin
      rd_dat = '0;
      if (sel) rd_dat[PORT_WIDTH-1:0] = rd_val;
   end

   assign pin_out = out_q;
   assign pin_oe  = dir_q;
   assign irq     = |(flags_q & mask_q);

endmodule

// File: rtl/io_gpio_bank.sv
// Purpose: multi-port GPIO bank on the 6-bit IO bus - address decode, port array, read/irq merge, arming.
// Latency: writes commit at the strobe edge; reads and io_hit combinational; irq combinational from flags.
// Backpressure: none; the IO bus has no stall, every strobe completes in one cycle.
// Ports: clk/rst (sync, active high); io_re/io_we/io_addr/io_out core access; io_in read data (0 if no hit);
//        io_hit for the top-level read mux; pin_in/pin_out/pin_oe pads, port k at [k*PORT_WIDTH +: PORT_WIDTH]; irq.
module io_gpio_bank
   import gpio_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int PORT_WIDTH  = 8,
   parameter int BASE_ADDR   = 0,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = EDGE_BOTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            io_re,
   input  logic                            io_we,
   input  logic [5:0]                      io_addr,
   input  logic [7:0]                      io_out,
   output logic [7:0]                      io_in,
   output logic                            io_hit,
   input  logic [NUM_PORTS*PORT_WIDTH-1:0] pin_in,
   output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_out,
   output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_oe,
   output logic                            irq
);

   localparam int ARM_LEN = SYNC_STAGES + 1;
   localparam int ARM_W   = $clog2(ARM_LEN + 1);

   logic [6:0]       rel;
   logic             in_range;
   logic [1:0]       port_idx;
   logic [2:0]       offset;
   logic [ARM_W-1:0] arm_cnt;
   logic             arm;
   logic [7:0]       port_rd  [NUM_PORTS];
   logic [NUM_PORTS-1:0] port_irq;

   // The bank always claims a 4-port window; an address below BASE_ADDR wraps and sets rel[6]
   assign rel      = {1'b0, io_addr} - 7'(BASE_ADDR);
   assign in_range = (rel[6:5] == 2'b00);
   assign port_idx = rel[4:3];
   assign offset   = rel[2:0];
   assign io_hit   = in_range & (io_re | io_we);

   // Holds off flag setting until the synchronisers and prev hold real pad samples
   assign arm = (arm_cnt == ARM_W'(ARM_LEN));

   always_ff @(posedge clk) begin
      if (rst)
         arm_cnt <= '0;
      else if (!arm)
         arm_cnt <= arm_cnt + ARM_W'(1);
   end

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      gpio_port #(
         .PORT_WIDTH  (PORT_WIDTH),
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE_MODE   (EDGE_MODE)
      ) u_port (
         .clk     (clk),
         .rst     (rst),
         .arm     (arm),
         .sel     (io_hit && (port_idx == 2'(k))),
         .we      (io_we),
         .offset  (offset),
         .wr_dat  (io_out[PORT_WIDTH-1:0]),
         .rd_dat  (port_rd[k]),
         .pin_in  (pin_in[k*PORT_WIDTH +: PORT_WIDTH]),
         .pin_out (pin_out[k*PORT_WIDTH +: PORT_WIDTH]),
         .pin_oe  (pin_oe[k*PORT_WIDTH +: PORT_WIDTH]),
         .irq     (port_irq[k])
      );
   end

   // At most one port is selected, so OR-merge is a mux
   always_comb begin
      io_in = '0;
      for (int k = 0; k < NUM_PORTS; k++) io_in = io_in | port_rd[k];
   end

   assign irq = |port_irq;

endmodule

// File: tb/tb_io_gpio_bank.sv
module tb_io_gpio_bank;

   localparam int NP   = 2;
   localparam int PW   = 8;
   localparam int BASE = 0;
   localparam int SS   = 2;
   localparam int EM   = 0;

   logic        clk;
   logic        rst, io_re, io_we, io_hit, irq;
   logic [5:0]  io_addr;
   logic [7:0]  io_out, io_in;
   logic [15:0] pin_in, pin_out, pin_oe;

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   io_gpio_bank #(
      .NUM_PORTS(NP), .PORT_WIDTH(PW), .BASE_ADDR(BASE), .SYNC_STAGES(SS), .EDGE_MODE(EM)
   ) dut (
      .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_addr(io_addr), .io_out(io_out),
      .io_in(io_in), .io_hit(io_hit), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
   );

   // ---------------- reference model ----------------
   logic [7:0]  m_dir   [NP];
   logic [7:0]  m_out   [NP];
   logic [7:0]  m_mask  [NP];
   logic [7:0]  m_flags [NP];
   logic [15:0] m_hist  [$];   // pad samples, oldest first; visible value lags the pad by SS edges
   int          m_since = 0;   // edges since reset released

   function automatic bit m_hit(input logic [5:0] a);
      return (int'(a) >= BASE) && (int'(a) < BASE + 32);
   endfunction

   function automatic logic [7:0] m_synced(input int p);
      logic [15:0] v;
      v = m_hist[m_hist.size() - SS];
      return v[p*8 +: 8];
   endfunction

   function automatic logic [7:0] m_read(input logic [5:0] a);
      int r, p, o;
      if (!m_hit(a)) return 8'h00;
      r = int'(a) - BASE;
      p = r / 8;
      o = r % 8;
      if (p >= NP) return 8'h00;
      case (o)
         0:       return m_dir[p];
         5:       return m_synced(p);
         6:       return m_mask[p];
         7:       return m_flags[p];
         default: return m_out[p];
      endcase
   endfunction

   function automatic logic m_irq();
      logic r;
      r = 1'b0;
      for (int p = 0; p < NP; p++) r = r | (|(m_flags[p] & m_mask[p]));
      return r;
   endfunction

   task automatic model_edge();
      logic [15:0] s, pv, ch;
      int r, p, o;
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            m_dir[i] = 0; m_out[i] = 0; m_mask[i] = 0; m_flags[i] = 0;
         end
         m_hist.delete();
         repeat (SS + 1) m_hist.push_back(16'h0000);
         m_since = 0;
      end else begin
         m_since++;
         s  = m_hist[m_hist.size() - SS];
         pv = m_hist[m_hist.size() - SS - 1];
         case (EM)
            1:       ch = s & ~pv;
            2:       ch = ~s & pv;
            default: ch = s ^ pv;
         endcase
         if (m_since <= SS + 1) ch = 16'h0000;
         if (io_we && m_hit(io_addr)) begin
            r = int'(io_addr) - BASE;
            p = r / 8;
            o = r % 8;
            if (p < NP) begin
               case (o)
                  0: m_dir[p]   = io_out;
                  1: m_out[p]   = io_out;
                  2: m_out[p]   = m_out[p] | io_out;
                  3: m_out[p]   = m_out[p] & ~io_out;
                  4: m_out[p]   = m_out[p] ^ io_out;
                  6: m_mask[p]  = io_out;
                  7: m_flags[p] = m_flags[p] & ~io_out;
                  default: ;
               endcase
            end
         end
         for (int i = 0; i < NP; i++) m_flags[i] = m_flags[i] | ch[i*8 +: 8];
         m_hist.push_back(pin_in);
         void'(m_hist.pop_front());
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [7:0] d);
      io_addr = a; io_out = d; io_we = 1'b1;
      step();
      io_we = 1'b0;
   endtask

   task automatic do_read(input logic [5:0] a, output logic [7:0] d, output logic h);
      io_addr = a; io_re = 1'b1;
      #1;
      d = io_in; h = io_hit;
      io_re = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] d; logic h;
      rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_addr = 6'd0; io_out = 8'h00; pin_in = 16'hFFFF;
      step(); step();
      n_tests++; if (pin_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pin_out: got %h expected 0000", pin_out); end
      n_tests++; if (pin_oe !== 16'h0000) begin n_fail++; $display("FAIL reset_pin_oe: got %h expected 0000", pin_oe); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
      n_tests++; if (io_hit !== 1'b0 || io_in !== 8'h00) begin n_fail++; $display("FAIL idle_bus: hit %b in %h expected 0 00", io_hit, io_in); end
      rst = 1'b0;
      repeat (10) step();
      do_read(6'd7, d, h);
      n_tests++; if (d !== 8'h00 || h !== 1'b1) begin n_fail++; $display("FAIL arm_flags0: got %h hit %b expected 00 hit 1", d, h); end
      do_read(6'd15, d, h);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL arm_flags1: got %h expected 00", d); end
      do_read(6'd5, d, h);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL in0_high: got %h expected ff", d); end
   endtask

   task automatic test_out_strobes();
      logic [7:0] d; logic h;
      do_write(6'd0, 8'hFF);
      n_tests++; if (pin_oe[7:0] !== 8'hFF) begin n_fail++; $display("FAIL dir0: got %h expected ff", pin_oe[7:0]); end
      do_write(6'd1, 8'hA0);
      n_tests++; if (pin_out[7:0] !== 8'hA0) begin n_fail++; $display("FAIL out_write: got %h expected a0", pin_out[7:0]); end
      do_write(6'd2, 8'h05);
      n_tests++; if (pin_out[7:0] !== 8'hA5) begin n_fail++; $display("FAIL outset: got %h expected a5", pin_out[7:0]); end
      do_read(6'd2, d, h);
      n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL read_outset: got %h expected a5", d); end
      do_write(6'd3, 8'h80);
      n_tests++; if (pin_out[7:0] !== 8'h25) begin n_fail++; $display("FAIL outclr: got %h expected 25", pin_out[7:0]); end
      do_read(6'd3, d, h);
      n_tests++; if (d !== 8'h25) begin n_fail++; $display("FAIL read_outclr: got %h expected 25", d); end
      do_write(6'd4, 8'h21);
      n_tests++; if (pin_out[7:0] !== 8'h04) begin n_fail++; $display("FAIL outtgl: got %h expected 04", pin_out[7:0]); end
      do_read(6'd4, d, h);
      n_tests++; if (d !== 8'h04) begin n_fail++; $display("FAIL read_outtgl: got %h expected 04", d); end
   endtask

   task automatic test_input_edges();
      logic [7:0] d; logic h;
      pin_in[15:8] = 8'h00;
      repeat (5) step();
      do_write(6'd15, 8'hFF);
      do_read(6'd15, d, h);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL flags1_cleared: got %h expected 00", d); end
      pin_in[15:8] = 8'h0F;
      step();
      do_read(6'd13, d, h);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL in1_edge1: got %h expected 00", d); end
      step();
      do_read(6'd13, d, h);
      n_tests++; if (d !== 8'h0F) begin n_fail++; $display("FAIL in1_edge2: got %h expected 0f", d); end
      do_read(6'd15, d, h);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL flags1_edge2: got %h expected 00", d); end
      step();
      do_read(6'd15, d, h);
      n_tests++; if (d !== 8'h0F) begin n_fail++; $display("FAIL flags1_edge3: got %h expected 0f", d); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b expected 0", irq); end
      do_write(6'd14, 8'h01);
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmasked: got %b expected 1", irq); end
   endtask

   task automatic test_w1c_collision();
      logic [7:0] d; logic h;
      pin_in[8] = 1'b0;
      repeat (4) step();
      pin_in[8] = 1'b1;
      step(); step();
      do_write(6'd15, 8'h01);   // this edge also detects the rising edge on bit 0
      do_read(6'd15, d, h);
      n_tests++; if (d !== 8'h0F) begin n_fail++; $display("FAIL w1c_collide: got %h expected 0f", d); end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_collide_irq: got %b expected 1", irq); end
      do_write(6'd15, 8'h0F);
      do_read(6'd15, d, h);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL w1c_plain: got %h expected 00", d); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_plain_irq: got %b expected 0", irq); end
   endtask

   task automatic test_rw_same_cycle();
      do_write(6'd1, 8'h11);
      io_addr = 6'd1; io_out = 8'h22; io_re = 1'b1; io_we = 1'b1;
      #1;
      n_tests++; if (io_in !== 8'h11) begin n_fail++; $display("FAIL rw_pre: got %h expected 11", io_in); end
      step();
      io_we = 1'b0;
      #1;
      n_tests++; if (io_in !== 8'h22) begin n_fail++; $display("FAIL rw_post: got %h expected 22", io_in); end
      io_addr = 6'h3F;
      #1;
      n_tests++; if (io_hit !== 1'b0 || io_in !== 8'h00) begin n_fail++; $display("FAIL out_of_range: hit %b in %h expected 0 00", io_hit, io_in); end
      io_addr = 6'h10;
      #1;
      n_tests++; if (io_hit !== 1'b1 || io_in !== 8'h00) begin n_fail++; $display("FAIL absent_port: hit %b in %h expected 1 00", io_hit, io_in); end
      io_re = 1'b0;
      do_write(6'h11, 8'hFF);
      n_tests++; if (pin_out !== {m_out[1], m_out[0]} || pin_out[7:0] !== 8'h22) begin n_fail++; $display("FAIL absent_port_write: got %h expected %h", pin_out, {m_out[1], m_out[0]}); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d; logic h;
      do_write(6'd7, 8'hFF);
      pin_in[7:0] = 8'hFC;
      repeat (4) step();
      do_read(6'd7, d, h);
      n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL mid_flags_pre: got %h expected 03", d); end
      do_write(6'd1, 8'h55);
      do_write(6'd6, 8'h03);
      n_tests++; if (irq !== 1'b1 || pin_out[7:0] !== 8'h55) begin n_fail++; $display("FAIL mid_pre: irq %b out %h expected 1 55", irq, pin_out[7:0]); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++; if (pin_out !== 16'h0000 || pin_oe !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_pins: out %h oe %h expected 0000 0000", pin_out, pin_oe); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b expected 0", irq); end
      do_read(6'd7, d, h);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL mid_reset_flags: got %h expected 00", d); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 99) == 0);
         io_re   = 1'($urandom_range(0, 1));
         io_we   = ($urandom_range(0, 2) == 0);
         io_addr = 6'($urandom_range(0, 47));
         io_out  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) pin_in = 16'($urandom);
         #1;
         if (io_re || io_we) begin
            n_tests++;
            if (io_hit !== m_hit(io_addr) || io_in !== m_read(io_addr)) begin
               n_fail++;
               $display("FAIL rand_read[%0d] addr %h: hit %b in %h expected %b %h", i, io_addr, io_hit, io_in, m_hit(io_addr), m_read(io_addr));
            end
         end
         step();
         n_tests++;
         if (pin_out !== {m_out[1], m_out[0]} || pin_oe !== {m_dir[1], m_dir[0]} || irq !== m_irq()) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: out %h oe %h irq %b expected %h %h %b", i, pin_out, pin_oe, irq,
                     {m_out[1], m_out[0]}, {m_dir[1], m_dir[0]}, m_irq());
         end
      end
      rst = 1'b0; io_re = 1'b0; io_we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_out_strobes();
      test_input_edges();
      test_w1c_collision();
      test_rw_same_cycle();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/io_gpio_bank.md
Name: io_gpio_bank

Overview:
- Parametrised multi-port GPIO peripheral on the mega_core 6-bit IO bus (io_re/io_we/io_addr/io_out/io_in).
- Replaces the single hard-wired 8-bit latch at IO address 0 with NUM_PORTS ports, each providing:
  - direction control;
  - set/clear/toggle output strobes;
  - a synchronised input;
  - pin-change interrupt flags with an aggregated irq.

Parameters:
- NUM_PORTS, 2, number of ports (1..4)
- PORT_WIDTH, 8, bits per port (1..8)
- BASE_ADDR, 0, first IO address; port k occupies BASE_ADDR+8k .. BASE_ADDR+8k+7; must satisfy BASE_ADDR+8*NUM_PORTS <= 64
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- EDGE_MODE, 0, pin-change sense: 0 both edges, 1 rising, 2 falling

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- io_re  in  1  IO read strobe
- io_we  in  1  IO write strobe
- io_addr  in  6  IO address
- io_out  in  8  write data from core
- io_in  out  8  read data to core; 0 when not hit
- io_hit  out  1  io_addr in this bank's range and (io_re|io_we); used by top-level read mux
- pin_in  in  NUM_PORTS*PORT_WIDTH  asynchronous pad inputs; port k at bits [k*PORT_WIDTH +: PORT_WIDTH]
- pin_out  out  NUM_PORTS*PORT_WIDTH  OUT register contents
- pin_oe  out  NUM_PORTS*PORT_WIDTH  DIR register contents (1 = drive)
- irq  out  1  OR over all ports of (INTFLAGS & INTMASK)

Behaviour:
- Register offsets within a port:
  - 0 DIR (rw)
  - 1 OUT (rw)
  - 2 OUTSET (w; OUT |= data; reads return OUT)
  - 3 OUTCLR (w; OUT &= ~data; reads return OUT)
  - 4 OUTTGL (w; OUT ^= data; reads return OUT)
  - 5 IN (ro; writes ignored)
  - 6 INTMASK (rw)
  - 7 INTFLAGS (read; write-1-to-clear)
- Width rules:
  - Data bits above PORT_WIDTH are ignored on write and read back as 0.
  - Addresses in range but with a port index >= NUM_PORTS: io_hit=1, read 0, writes ignored.
- Writes take effect at the clk edge where io_we=1. Reads are combinational from current register state.
- io_re and io_we in the same cycle: read returns the pre-write value; the write commits at the edge.
- Reset (rst=1 at an edge): DIR, OUT, INTMASK, INTFLAGS and the synchroniser chains clear to 0.
- Outputs under reset: pin_out=0, pin_oe=0, irq=0. io_in and io_hit are purely address-decoded and are 0 whenever no strobe is active.
- Input path:
  - pin_in passes through SYNC_STAGES flops.
  - IN shows the synchronised value, so a pad change is readable after SYNC_STAGES edges.
  - A prev register holds the last synchronised sample.
- Edge detection:
  - A bit sets INTFLAGS at the next edge after the synchronised value changes in the sensed direction.
  - Latency from pad change to flag set is SYNC_STAGES+1 edges.
  - irq follows combinationally from the flag registers.
- Post-reset arming: a per-bank counter suppresses flag setting for SYNC_STAGES+1 cycles after reset deasserts, so a pad held high through reset raises no spurious flag. prev still tracks during this window.
- Simultaneous flag set and write-1-to-clear on the same bit: the set wins (flag stays 1).
- INTMASK gates irq only. Flags latch regardless of mask.
- A reset asserted mid-sequence aborts everything and returns the block to the reset state on that edge. No pending state survives.

Decomposition:
- Package gpio_pkg:
  - register offset constants (GPIO_DIR, GPIO_OUT, GPIO_OUTSET, GPIO_OUTCLR, GPIO_OUTTGL, GPIO_IN, GPIO_INTMASK, GPIO_INTFLAGS);
  - EDGE_MODE encodings.
- Sub-module gpio_port:
  - one port: registers, synchroniser, edge detect, per-port irq;
  - takes a local 3-bit offset plus a select.
- io_gpio_bank contains the address decode, generate-instantiates NUM_PORTS gpio_port, ORs the read data and irqs, and holds the arming counter.

Test Plan:
- Reset with pin_in=all 1s, NUM_PORTS=2 -> pin_out=0, pin_oe=0, irq=0. INTFLAGS read 0x00 on both ports after 10 cycles (arming suppression).
- Write DIR(0)=0xFF, OUT(0)=0xA0, OUTSET=0x05, OUTCLR=0x80, OUTTGL=0x21 -> pin_out[7:0] sequence 0xA0, 0xA5, 0x25, 0x04. Reads of offsets 2/3/4 return current OUT.
- pin_in[15:8] 0x00->0x0F, EDGE_MODE=0 -> IN(1)=0x0F after 2 edges; INTFLAGS(1)=0x0F after 3 edges; irq=0 until INTMASK(1)=0x01 written, then irq=1.
- Write INTFLAGS(1)=0x01 in the same cycle a new rising edge on bit0 is detected -> bit0 stays 1. Next plain write of 0x0F -> INTFLAGS=0x00, irq=0.
- io_re=io_we=1 at OUT(0) with OUT=0x11, data=0x22 -> io_in=0x11 that cycle, 0x22 next cycle. io_addr=0x3F with BASE_ADDR=0 -> io_hit=0, io_in=0.
- Assert rst for 1 cycle mid-stream with OUT=0x55, INTFLAGS=0x03 -> next cycle pin_out=0, INTFLAGS=0, irq=0.
